ncl_threshold_gate: RTL and testbench



---
 rtl/ncl_threshold_gate.sv | 81 ++++++++
 tb/tb_ncl_threshold_gate.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ncl_threshold_gate.sv
// ncl_threshold_gate: clocked bank of LANES independent NCL M-of-N threshold gates with
// hysteresis. With THRESHOLD=1 each lane is a registered OR (TH12); with THRESHOLD=N_INPUTS
// each lane is a C-element (TH22); HAS_RESET=1 adds a synchronous init (TH22N style).
//
// Ports:
//   clk   - sole clock, all state updates on the rising edge
//   init  - synchronous active-high reset, honoured only when HAS_RESET=1
//   a     - gate inputs, lane k uses a[k*N_INPUTS +: N_INPUTS]
//   z     - registered gate outputs, lane k drives z[k]
module ncl_threshold_gate #(
  parameter int unsigned N_INPUTS  = 2,
  parameter int unsigned THRESHOLD = 2,
  parameter int unsigned LANES     = 1,
  parameter int unsigned HAS_RESET = 1,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic                         clk,
  input  logic                         init,
  input  logic [LANES*N_INPUTS-1:0]    a,
  output logic [LANES-1:0]             z
);

  // Reject illegal parameter combinations at elaboration time.
  if (N_INPUTS == 0 || N_INPUTS > 8) begin : gen_bad_n
    $error("ncl_threshold_gate: N_INPUTS must be in 1..8");
  end
  if (THRESHOLD == 0 || THRESHOLD > N_INPUTS) begin : gen_bad_m
    $error("ncl_threshold_gate: THRESHOLD must be in 1..N_INPUTS");
  end
  if (LANES == 0 || LANES > 64) begin : gen_bad_lanes
    $error("ncl_threshold_gate: LANES must be in 1..64");
  end
  if (HAS_RESET > 1 || RESET_VAL > 1) begin : gen_bad_rst
    $error("ncl_threshold_gate: HAS_RESET and RESET_VAL must be 0 or 1");
  end

  // Wide enough to hold a count of 0..N_INPUTS.
  localparam int unsigned CntW = $clog2(N_INPUTS + 1);
  localparam logic [LANES-1:0] RstVec = (RESET_VAL != 0) ? {LANES{1'b1}} : {LANES{1'b0}};

  logic [CntW-1:0]  cnt [LANES];
  logic [LANES-1:0] z_d;
  // Initial value provides the power-up state when no reset logic is built.
  logic [LANES-1:0] z_q = RstVec;

  always_comb begin
    z_d = z_q;
    for (int k = 0; k < LANES; k++) begin
      cnt[k] = '0;
      for (int i = 0; i < N_INPUTS; i++) begin
        cnt[k] = cnt[k] + CntW'(a[k*N_INPUTS+i]);
      end
      // THRESHOLD >= 1 keeps the set and clear conditions disjoint.
      if (cnt[k] >= CntW'(THRESHOLD)) begin
        z_d[k] = 1'b1;
      end else if (cnt[k] == '0) begin
        z_d[k] = 1'b0;
      end
    end
  end

  if (HAS_RESET != 0) begin : gen_reset
    always_ff @(posedge clk) begin
      if (init) begin
        z_q <= RstVec;
      end else begin
        z_q <= z_d;
      end
    end
  end else begin : gen_no_reset
    logic unused_init;
    assign unused_init = init;

    always_ff @(posedge clk) begin
      z_q <= z_d;
    end
  end

  assign z = z_q;

endmodule

// File: tb/tb_ncl_threshold_gate.sv
// Bench for ncl_threshold_gate: five configurations side by side (TH22N, TH22, TH12,
// 4-lane 2-of-3, TH22N with reset value 1). Directed table rows and hand sequences cover the
// named corner cases; a randomized phase compares every instance against a rule-based model.
module tb_ncl_threshold_gate;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        init_th22n = 1'b0, init_th22 = 1'b0, init_th12 = 1'b0;
  logic        init_ml = 1'b0, init_rv1 = 1'b0;
  logic [1:0]  a_th22n = '0, a_th22 = '0, a_th12 = '0, a_rv1 = '0;
  logic [11:0] a_ml = '0;
  logic        z_th22n, z_th22, z_th12, z_rv1;
  logic [3:0]  z_ml;

  ncl_threshold_gate #(.N_INPUTS(2), .THRESHOLD(2), .LANES(1), .HAS_RESET(1), .RESET_VAL(0))
    u_th22n (.clk(clk), .init(init_th22n), .a(a_th22n), .z(z_th22n));
  ncl_threshold_gate #(.N_INPUTS(2), .THRESHOLD(2), .LANES(1), .HAS_RESET(0), .RESET_VAL(0))
    u_th22 (.clk(clk), .init(init_th22), .a(a_th22), .z(z_th22));
  ncl_threshold_gate #(.N_INPUTS(2), .THRESHOLD(1), .LANES(1), .HAS_RESET(0), .RESET_VAL(0))
    u_th12 (.clk(clk), .init(init_th12), .a(a_th12), .z(z_th12));
  ncl_threshold_gate #(.N_INPUTS(3), .THRESHOLD(2), .LANES(4), .HAS_RESET(1), .RESET_VAL(0))
    u_ml (.clk(clk), .init(init_ml), .a(a_ml), .z(z_ml));
  ncl_threshold_gate #(.N_INPUTS(2), .THRESHOLD(2), .LANES(1), .HAS_RESET(1), .RESET_VAL(1))
    u_rv1 (.clk(clk), .init(init_rv1), .a(a_rv1), .z(z_rv1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Next output of one gate from the rule list: init wins, then set, then clear, else hold.
  function automatic logic ref_next(input logic cur, input int cnt, input int m,
                                    input bit has_rst, input logic ini, input logic rv);
    if (has_rst && ini) return rv;
    if (cnt >= m)       return 1'b1;
    if (cnt == 0)       return 1'b0;
    return cur;
  endfunction

  // dut: 0=TH22N 1=TH22 2=TH12 3=TH22N with RESET_VAL=1. z is the value after the edge.
  typedef struct {
    int         dut;
    logic       init;
    logic [1:0] a;
    logic       z;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic exp_th22n, exp_th22, exp_th12, exp_rv1;
    logic [3:0] exp_ml;
    logic [2:0] lane;
    logic act;

    // TH22N: init held two edges with a=11, release, then mid-operation reset.
    tbl.push_back('{0, 1'b1, 2'b11, 1'b0});
    tbl.push_back('{0, 1'b1, 2'b11, 1'b0});
    tbl.push_back('{0, 1'b0, 2'b11, 1'b1});
    tbl.push_back('{0, 1'b1, 2'b11, 1'b0});
    tbl.push_back('{0, 1'b0, 2'b10, 1'b0});
    tbl.push_back('{0, 1'b0, 2'b11, 1'b1});
    tbl.push_back('{0, 1'b0, 2'b01, 1'b1});
    tbl.push_back('{0, 1'b0, 2'b00, 1'b0});
    // TH22 hysteresis.
    tbl.push_back('{1, 1'b0, 2'b00, 1'b0});
    tbl.push_back('{1, 1'b0, 2'b01, 1'b0});
    tbl.push_back('{1, 1'b0, 2'b11, 1'b1});
    tbl.push_back('{1, 1'b0, 2'b10, 1'b1});
    tbl.push_back('{1, 1'b0, 2'b00, 1'b0});
    tbl.push_back('{1, 1'b0, 2'b10, 1'b0});
    // TH12 registered OR; init has no effect.
    tbl.push_back('{2, 1'b0, 2'b00, 1'b0});
    tbl.push_back('{2, 1'b0, 2'b01, 1'b1});
    tbl.push_back('{2, 1'b0, 2'b10, 1'b1});
    tbl.push_back('{2, 1'b0, 2'b11, 1'b1});
    tbl.push_back('{2, 1'b0, 2'b00, 1'b0});
    tbl.push_back('{2, 1'b1, 2'b11, 1'b1});
    tbl.push_back('{2, 1'b1, 2'b00, 1'b0});
    tbl.push_back('{2, 1'b0, 2'b00, 1'b0});
    // RESET_VAL=1: init forces 1, release with cnt=0 clears, partial input holds.
    tbl.push_back('{3, 1'b1, 2'b00, 1'b1});
    tbl.push_back('{3, 1'b0, 2'b00, 1'b0});
    tbl.push_back('{3, 1'b0, 2'b01, 1'b0});
    tbl.push_back('{3, 1'b1, 2'b01, 1'b1});
    tbl.push_back('{3, 1'b0, 2'b01, 1'b1});
    tbl.push_back('{3, 1'b0, 2'b11, 1'b1});
    tbl.push_back('{3, 1'b0, 2'b00, 1'b0});

    // Power-up value of the reset-less gates.
    #1;
    check("powerup_th22", {3'b0, z_th22}, 4'b0000);
    check("powerup_th12", {3'b0, z_th12}, 4'b0000);

    foreach (tbl[i]) begin
      case (tbl[i].dut)
        0:       begin init_th22n = tbl[i].init; a_th22n = tbl[i].a; end
        1:       begin init_th22  = tbl[i].init; a_th22  = tbl[i].a; end
        2:       begin init_th12  = tbl[i].init; a_th12  = tbl[i].a; end
        default: begin init_rv1   = tbl[i].init; a_rv1   = tbl[i].a; end
      endcase
      tick();
      case (tbl[i].dut)
        0:       act = z_th22n;
        1:       act = z_th22;
        2:       act = z_th12;
        default: act = z_rv1;
      endcase
      check($sformatf("table[%0d] dut%0d a=%b init=%b", i, tbl[i].dut, tbl[i].a, tbl[i].init),
            {3'b0, act}, {3'b0, tbl[i].z});
    end

    // Multi-lane: lanes 011, 001, 000, 111 (lane0..lane3).
    init_ml = 1'b1;
    tick();
    check("ml_init", z_ml, 4'b0000);
    init_ml = 1'b0;
    a_ml = {3'b111, 3'b000, 3'b001, 3'b011};
    tick();
    check("ml_first", z_ml, 4'b1001);
    a_ml = {3'b111, 3'b000, 3'b101, 3'b011};
    tick();
    check("ml_lane1_set", z_ml, 4'b1011);
    a_ml = {3'b001, 3'b100, 3'b100, 3'b000};
    tick();
    check("ml_hold_clear", z_ml, 4'b1010);
    init_ml = 1'b1;
    a_ml = '1;
    tick();
    check("ml_mid_init", z_ml, 4'b0000);
    init_ml = 1'b0;

    // Bring every gate to a known NULL state, then randomize.
    a_th22n = '0; a_th22 = '0; a_th12 = '0; a_rv1 = '0; a_ml = '0;
    init_th22n = 1'b0; init_th22 = 1'b0; init_th12 = 1'b0; init_rv1 = 1'b0;
    tick();
    exp_th22n = 1'b0; exp_th22 = 1'b0; exp_th12 = 1'b0; exp_rv1 = 1'b0; exp_ml = '0;
    check("rand_start", {z_rv1, z_th12, z_th22, z_th22n}, 4'b0000);

    for (int c = 0; c < 400; c++) begin
      a_th22n = 2'($urandom); a_th22 = 2'($urandom); a_th12 = 2'($urandom);
      a_rv1 = 2'($urandom); a_ml = 12'($urandom);
      init_th22n = ($urandom_range(0, 7) == 0);
      init_th22  = ($urandom_range(0, 3) == 0);
      init_th12  = ($urandom_range(0, 3) == 0);
      init_ml    = ($urandom_range(0, 7) == 0);
      init_rv1   = ($urandom_range(0, 7) == 0);
      exp_th22n = ref_next(exp_th22n, $countones(a_th22n), 2, 1'b1, init_th22n, 1'b0);
      exp_th22  = ref_next(exp_th22,  $countones(a_th22),  2, 1'b0, init_th22,  1'b0);
      exp_th12  = ref_next(exp_th12,  $countones(a_th12),  1, 1'b0, init_th12,  1'b0);
      exp_rv1   = ref_next(exp_rv1,   $countones(a_rv1),   2, 1'b1, init_rv1,   1'b1);
      for (int k = 0; k < 4; k++) begin
        lane = a_ml[k*3 +: 3];
        exp_ml[k] = ref_next(exp_ml[k], $countones(lane), 2, 1'b1, init_ml, 1'b0);
      end
      tick();
      check($sformatf("rand[%0d] th22n", c), {3'b0, z_th22n}, {3'b0, exp_th22n});
      check($sformatf("rand[%0d] th22", c),  {3'b0, z_th22},  {3'b0, exp_th22});
      check($sformatf("rand[%0d] th12", c),  {3'b0, z_th12},  {3'b0, exp_th12});
      check($sformatf("rand[%0d] rv1", c),   {3'b0, z_rv1},   {3'b0, exp_rv1});
      check($sformatf("rand[%0d] ml", c),    z_ml,            exp_ml);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
